// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler sharing one serial Mealy sequence detector among NREQ requesters.
// Build option: define SEQ_SCHED_NOOVERLAP_EN for non-overlapping pattern detection.
module seq_detect_scheduler #(
  parameter int unsigned      NREQ    = 4,
  parameter int unsigned      WIDTH   = 16,
  parameter int unsigned      PLEN    = 4,
  parameter logic [PLEN-1:0]  PATTERN = 4'b1011,
  localparam int unsigned     IDW     = $clog2(NREQ),
  localparam int unsigned     CNTW    = $clog2(WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data_i,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  bit_o,
  output logic                  bit_valid,
  output logic                  match_o,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [CNTW-1:0]       match_cnt
);

  typedef enum logic [1:0] {StIdle, StGrant, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [IDW-1:0]    rr_q, rr_d;
  logic [IDW-1:0]    win_q, win_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [PLEN-2:0]   hist_q, hist_d;
  logic [CNTW-1:0]   idx_q, idx_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]    done_id_q, done_id_d;
  logic [CNTW-1:0]   match_cnt_q, match_cnt_d;

  logic              in_shift;
  logic [PLEN-1:0]   hist_cat;
  logic [PLEN-2:0]   hist_next;
  logic [IDW-1:0]    cand;
  logic [IDW-1:0]    pick;
  logic              found;

  assign in_shift = (state_q == StShift);
  assign bit_o    = in_shift & shift_q[0];
  assign hist_cat = {hist_q, bit_o};
  assign match_o  = in_shift & (hist_cat == PATTERN);

`ifdef SEQ_SCHED_NOOVERLAP_EN
  // A matched bit is consumed so it cannot start the next match.
  assign hist_next = match_o ? '0 : hist_cat[PLEN-2:0];
`else
  assign hist_next = hist_cat[PLEN-2:0];
`endif

  // First set request at or above rr_q, wrapping around.
  always_comb begin
    cand  = rr_q;
    pick  = rr_q;
    found = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      cand = IDW'((int'(rr_q) + i) % int'(NREQ));
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    win_d       = win_q;
    shift_d     = shift_q;
    hist_d      = hist_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    done_id_d   = done_id_q;
    match_cnt_d = match_cnt_q;
    gnt         = '0;
    busy        = 1'b0;
    bit_valid   = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          win_d   = pick;
          state_d = StGrant;
        end
      end
      StGrant: begin
        gnt[win_q] = 1'b1;
        busy       = 1'b1;
        shift_d    = data_i[win_q*WIDTH +: WIDTH];
        hist_d     = '0;
        cnt_d      = '0;
        idx_d      = '0;
        state_d    = StShift;
      end
      StShift: begin
        busy      = 1'b1;
        bit_valid = 1'b1;
        shift_d   = shift_q >> 1;
        hist_d    = hist_next;
        cnt_d     = cnt_q + CNTW'(match_o);
        idx_d     = idx_q + 1'b1;
        if (idx_q == CNTW'(WIDTH - 1)) begin
          // Result registers load here so they are valid during the done cycle.
          done_id_d   = win_q;
          match_cnt_d = cnt_d;
          state_d     = StDone;
        end
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        rr_d    = IDW'((int'(win_q) + 1) % int'(NREQ));
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_q        <= '0;
      win_q       <= '0;
      shift_q     <= '0;
      hist_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      done_id_q   <= '0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      win_q       <= win_d;
      shift_q     <= shift_d;
      hist_q      <= hist_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      done_id_q   <= done_id_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign done_id   = done_id_q;
  assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed self-checking bench for seq_detect_scheduler (NREQ=4, WIDTH=16, PATTERN=1011).
module tb_seq_detect_scheduler;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;

`ifdef SEQ_SCHED_NOOVERLAP_EN
  localparam logic [15:0] M6D = 16'h0008;
  localparam int          C6D = 1;
`else
  localparam logic [15:0] M6D = 16'h0048;
  localparam int          C6D = 2;
`endif

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data_i;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  bit_o;
  logic                  bit_valid;
  logic                  match_o;
  logic                  done;
  logic [1:0]            done_id;
  logic [4:0]            match_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  seq_detect_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_i    (data_i),
    .gnt       (gnt),
    .busy      (busy),
    .bit_o     (bit_o),
    .bit_valid (bit_valid),
    .match_o   (match_o),
    .done      (done),
    .done_id   (done_id),
    .match_cnt (match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_word(input int id, input logic [15:0] w);
    data_i[id*WIDTH +: WIDTH] = w;
  endtask

  // Waits for a grant, then checks the serial stream, match positions and result.
  task automatic serve(input string tag, input logic [3:0] exp_gnt, input int exp_id,
                       input logic [15:0] word, input logic [15:0] exp_mask,
                       input int exp_cnt, input bit drop, output int gnt_cyc,
                       output int wait_n);
    int          n;
    int          nvalid;
    logic [15:0] bits;
    logic [15:0] mask;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == '0 && n < 40);
    wait_n  = n;
    gnt_cyc = cyc;
    check({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    if (gnt == '0) return;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    if (drop) req = req & ~gnt;
    bits   = '0;
    mask   = '0;
    nvalid = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      nvalid += int'(bit_valid);
      bits[i] = bit_o;
      mask[i] = match_o;
    end
    check({tag, "_nvalid"}, 32'(nvalid), 32'd16);
    check({tag, "_bits"}, 32'(bits), 32'(word));
    check({tag, "_mask"}, 32'(mask), 32'(exp_mask));
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_id"}, 32'(done_id), 32'(exp_id));
    check({tag, "_cnt"}, 32'(match_cnt), 32'(exp_cnt));
    check({tag, "_bv_off"}, 32'(bit_valid), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_bit"}, 32'({bit_o, bit_valid, match_o}), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_result"}, 32'({done_id, match_cnt}), 32'd0);
  endtask

  logic [15:0] fw   [4] = '{16'h006D, 16'h000D, 16'hDDDD, 16'h0000};
  logic [15:0] fm   [4] = '{M6D, 16'h0008, 16'h8888, 16'h0000};
  int          fc   [4] = '{C6D, 1, 4, 0};

  initial begin
    int gc;
    int prev;
    int wn;
    int act;
    rst    = 1'b1;
    req    = '0;
    data_i = '0;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    act = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt != '0 || busy || done || bit_valid) act++;
    end
    check("idle_quiet", 32'(act), 32'd0);

    // Fairness: all requests held, rr_ptr starts at 0.
    for (int id = 0; id < 4; id++) set_word(id, fw[id]);
    req  = 4'hF;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      serve($sformatf("fair%0d", k), 4'(4'b0001 << (k % 4)), k % 4, fw[k % 4],
            fm[k % 4], fc[k % 4], 1'b0, gc, wn);
      if (k > 0) check($sformatf("fair_gap%0d", k), 32'(gc - prev), 32'd19);
      prev = gc;
    end
    req = '0;
    repeat (3) @(negedge clk);

    // Single request from 0 with rr_ptr at 1: search wraps to 0.
    set_word(0, 16'h006D);
    req = 4'b0001;
    serve("single", 4'b0001, 0, 16'h006D, M6D, C6D, 1'b1, gc, wn);
    check("req_to_gnt", 32'(wn), 32'd1);
    repeat (2) @(negedge clk);
    check("held_id", 32'(done_id), 32'd0);
    check("held_cnt", 32'(match_cnt), 32'(C6D));

    set_word(2, 16'h0000);
    req = 4'b0100;
    serve("zeros", 4'b0100, 2, 16'h0000, 16'h0000, 0, 1'b1, gc, wn);
    set_word(2, 16'hFFFF);
    req = 4'b0100;
    serve("ones", 4'b0100, 2, 16'hFFFF, 16'h0000, 0, 1'b1, gc, wn);

    // rr_ptr is 3 here: 0 must win before 2.
    set_word(0, 16'h000D);
    set_word(2, 16'hDDDD);
    req = 4'b0101;
    serve("wrap0", 4'b0001, 0, 16'h000D, 16'h0008, 1, 1'b1, gc, wn);
    serve("wrap2", 4'b0100, 2, 16'hDDDD, 16'h8888, 4, 1'b1, gc, wn);

    // Reset while requester 1's bit 7 is on the line.
    set_word(1, 16'h006D);
    req = 4'b0010;
    wn  = 0;
    do begin
      @(negedge clk);
      wn++;
    end while (gnt == '0 && wn < 40);
    check("mid_gnt", 32'(gnt), 32'b0010);
    repeat (8) @(negedge clk);
    check("mid_bv", 32'(bit_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    act = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (done || gnt != '0) act++;
    end
    check("mid_no_done", 32'(act), 32'd0);
    rst = 1'b0;
    serve("after_rst", 4'b0010, 1, 16'h006D, M6D, C6D, 1'b1, gc, wn);
    check("after_rst_lat", 32'(wn), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_detect_scheduler.md
Name: seq_detect_scheduler

Overview:
- Shares one Mealy serial sequence detector among NREQ requesters.
- Each requester offers a WIDTH-bit word. The block grants requesters round-robin, serializes the granted word LSB-first through the detector, and counts pattern matches.
- It returns the match count and the requester id with a one-cycle done pulse.
- It sits between parallel producers and the serial detector datapath.

Parameters:
- NREQ, 4, number of requesters (≥2).
- WIDTH, 16, bits per word.
- PLEN, 4, pattern length in bits (2..WIDTH).
- PATTERN, 4'b1011, target sequence. The MSB is the first bit to arrive.
- Derived localparams: IDW = $clog2(NREQ); CNTW = $clog2(WIDTH+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  request per requester. Must be held with its data until granted.
- data_i  in  NREQ*WIDTH  requester k's word is bits [k*WIDTH +: WIDTH].
- gnt  out  NREQ  one-hot, one-cycle pulse when a word is accepted.
- busy  out  1  high from the grant cycle through the done cycle.
- bit_o  out  1  serial bit currently presented to the detector.
- bit_valid  out  1  bit_o is valid this cycle.
- match_o  out  1  Mealy detector output (combinational on the current bit).
- done  out  1  one-cycle pulse when a result is valid.
- done_id  out  IDW  requester index of the finished word.
- match_cnt  out  CNTW  number of matches found in the finished word.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; rr_ptr=0; history, shift register, bit index and counter cleared.
  - gnt=0, busy=0, bit_o=0, bit_valid=0, match_o=0, done=0, done_id=0, match_cnt=0.
  - Reset mid-word aborts the word: no done pulse, no grant re-issue. The requester must re-request.
- FSM states: IDLE, GRANT, SHIFT, DONE.
- IDLE:
  - If any req is set, choose the first set bit searching from rr_ptr upward with wrap-around.
  - Register the winner and go to GRANT.
  - With no requests, stay in IDLE.
- GRANT (1 cycle):
  - gnt[winner]=1, busy=1.
  - Latch data_i slice into the shift register.
  - Clear history and match counter; bit index=0.
  - Go to SHIFT.
- SHIFT (exactly WIDTH cycles):
  - bit_valid=1; bit_o = shift register bit 0.
  - match_o = ({history[PLEN-2:0], bit_o} == PATTERN), qualified by bit_valid.
  - On each edge: shift the register right; history <= {history[PLEN-2:0], bit_o}; counter += match_o; index += 1.
  - After the bit with index WIDTH-1, go to DONE.
  - Matches overlap: history is not cleared on a match.
- DONE (1 cycle):
  - done=1; done_id=winner; match_cnt=final count; bit_valid=0.
  - rr_ptr <= (winner+1) mod NREQ. Go to IDLE.
- Held outputs: done_id and match_cnt hold their values until the next DONE. Only done pulses.
- Latency: grant-to-done = WIDTH+1 cycles. req-to-gnt = 1 cycle from IDLE. Throughput is one word per WIDTH+3 cycles.
- Request changes: req changes outside IDLE are ignored; arbitration samples only in IDLE. Dropping req after gnt has no effect on the word in flight.
- Counter width: counter cannot overflow, since the maximum is WIDTH-PLEN+1 < 2^CNTW.
- Data sampling: data_i is sampled only in the GRANT cycle.
- Outside SHIFT: bit_o=0 and match_o=0.

Optional Feature:
- Macro SEQ_SCHED_NOOVERLAP_EN.
- Defined: non-overlapping detection. On any cycle with match_o=1, history is cleared to 0 instead of shifting in bit_o. A bit may contribute to only one match.
- Undefined: overlapping detection as described in Behaviour.
- Interface and timing are identical in both builds.

Test Plan:
- Reset then idle: rst=1 for 5 time units, req=0 → all outputs 0, state IDLE, no gnt for 20 cycles.
- Single request, overlapping: req=4'b0001, data[0]=16'h006D (LSB-first 1,0,1,1,0,1,1,0...) → gnt=0001 one cycle after request, 16 bit_valid cycles, match_o high at bit indices 3 and 6, done after 17 cycles with done_id=0 and match_cnt=2. With SEQ_SCHED_NOOVERLAP_EN: match_cnt=1.
- No-match words: data 16'h0000, then 16'hFFFF from requester 2 → match_cnt=0 both times, done_id=2.
- Fairness: req=4'b1111 held continuously, distinct words → gnt order 0001, 0010, 0100, 1000, 0001. Consecutive gnt pulses are 19 cycles apart.
- Wrap and skip: rr_ptr=3 after serving requester 2, req=4'b0101 → requester 0 is granted next, then 2.
- Reset mid-operation: assert rst at SHIFT bit 7 of requester 1 → outputs immediately 0, no done pulse. After release with req=4'b0010 still held, a fresh grant to requester 1 and a correct full count.
